// File: rtl/mole_scheduler.sv
// -----------------------------------------------------------------------------
// mole_scheduler
//   Whack-a-mole game scheduler. After a random idle gap it picks a random hole
//   from the upstream LFSR word, raises a mole there for UP_TIME cycles, and
//   scores a hit (correct strike while up) or a miss (mole timed out). Score
//   and miss counters saturate at 16'hFFFF.
//
// Handshake/strobe semantics: hit_valid is a one-cycle input strobe qualified
//   by hit_index; it is only acted on while a mole is up and only when
//   hit_index matches mole_pos. hit_pulse / miss_pulse are one-cycle output
//   strobes and are mutually exclusive. There is no back-pressure.
//
// Optional feature: define MOLE_NO_REPEAT_EN to forbid a mole appearing in the
//   same hole as the previous mole (the first mole after reset is exempt).
//
// Ports:
//   clock       in   single clock, rising edge
//   reset       in   synchronous active-high reset
//   rand_data   in   32-bit free-running pseudo-random word
//   enable      in   game running; low forces IDLE
//   hit_valid   in   player strike strobe
//   hit_index   in   hole struck (valid with hit_valid)
//   mole_valid  out  a mole is currently up
//   mole_pos    out  hole of current/last mole
//   hit_pulse   out  correct hit strobe
//   miss_pulse  out  timed-out mole strobe
//   score       out  correct hit count
//   misses      out  timed-out mole count
//   dbg_state   out  FSM state (0 IDLE, 1 WAIT_GAP, 2 PICK, 3 UP)
// -----------------------------------------------------------------------------
module mole_scheduler #(
    parameter int NUM_HOLES = 9,
    parameter int MIN_GAP   = 25000000,
    parameter int GAP_BITS  = 24,
    parameter int UP_TIME   = 50000000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] rand_data,
    input  logic        enable,
    input  logic        hit_valid,
    input  logic [3:0]  hit_index,
    output logic        mole_valid,
    output logic [3:0]  mole_pos,
    output logic        hit_pulse,
    output logic        miss_pulse,
    output logic [15:0] score,
    output logic [15:0] misses,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_GAP = 2'd1,
        PICK     = 2'd2,
        UP       = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] gap_cnt_q, gap_cnt_d;
    logic [31:0] up_cnt_q, up_cnt_d;
    logic        mole_valid_q, mole_valid_d;
    logic [3:0]  mole_pos_q, mole_pos_d;
    logic        hit_pulse_q, hit_pulse_d;
    logic        miss_pulse_q, miss_pulse_d;
    logic [15:0] score_q, score_d;
    logic [15:0] misses_q, misses_d;
`ifdef MOLE_NO_REPEAT_EN
    logic        has_prev_q, has_prev_d;
`endif

    logic [31:0] gap_load;
    logic [3:0]  cand;
    logic        cand_ok;
    logic        correct_hit;
    logic        unused_rand;

    // Only a slice of the random word is consumed; fold the rest away.
    assign unused_rand = ^rand_data;

    assign gap_load    = 32'(MIN_GAP) + 32'(rand_data[GAP_BITS+7:8]);
    assign cand        = rand_data[3:0];
    assign correct_hit = hit_valid && (hit_index == mole_pos_q);

`ifdef MOLE_NO_REPEAT_EN
    assign cand_ok = ({1'b0, cand} < 5'(NUM_HOLES)) &&
                     !(has_prev_q && (cand == mole_pos_q));
`else
    assign cand_ok = ({1'b0, cand} < 5'(NUM_HOLES));
`endif

    always_comb begin
        state_d      = state_q;
        gap_cnt_d    = gap_cnt_q;
        up_cnt_d     = up_cnt_q;
        mole_valid_d = mole_valid_q;
        mole_pos_d   = mole_pos_q;
        hit_pulse_d  = 1'b0;
        miss_pulse_d = 1'b0;
        score_d      = score_q;
        misses_d     = misses_q;
`ifdef MOLE_NO_REPEAT_EN
        has_prev_d   = has_prev_q;
`endif

        if (!enable) begin
            state_d      = IDLE;
            mole_valid_d = 1'b0;
            gap_cnt_d    = '0;
            up_cnt_d     = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d   = WAIT_GAP;
                    gap_cnt_d = gap_load;
                end
                WAIT_GAP: begin
                    // Count n..1, so the state lasts exactly the loaded count.
                    if (gap_cnt_q <= 32'd1) begin
                        state_d   = PICK;
                        gap_cnt_d = '0;
                    end else begin
                        gap_cnt_d = gap_cnt_q - 32'd1;
                    end
                end
                PICK: begin
                    if (cand_ok) begin
                        state_d      = UP;
                        mole_valid_d = 1'b1;
                        mole_pos_d   = cand;
                        up_cnt_d     = 32'(UP_TIME);
`ifdef MOLE_NO_REPEAT_EN
                        has_prev_d   = 1'b1;
`endif
                    end
                end
                UP: begin
                    // A correct hit wins even on the expiry cycle.
                    if (correct_hit) begin
                        state_d      = WAIT_GAP;
                        mole_valid_d = 1'b0;
                        hit_pulse_d  = 1'b1;
                        up_cnt_d     = '0;
                        gap_cnt_d    = gap_load;
                        if (score_q != 16'hFFFF) score_d = score_q + 16'd1;
                    end else if (up_cnt_q <= 32'd1) begin
                        state_d      = WAIT_GAP;
                        mole_valid_d = 1'b0;
                        miss_pulse_d = 1'b1;
                        up_cnt_d     = '0;
                        gap_cnt_d    = gap_load;
                        if (misses_q != 16'hFFFF) misses_d = misses_q + 16'd1;
                    end else begin
                        up_cnt_d = up_cnt_q - 32'd1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            gap_cnt_q    <= '0;
            up_cnt_q     <= '0;
            mole_valid_q <= 1'b0;
            mole_pos_q   <= '0;
            hit_pulse_q  <= 1'b0;
            miss_pulse_q <= 1'b0;
            score_q      <= '0;
            misses_q     <= '0;
`ifdef MOLE_NO_REPEAT_EN
            has_prev_q   <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            gap_cnt_q    <= gap_cnt_d;
            up_cnt_q     <= up_cnt_d;
            mole_valid_q <= mole_valid_d;
            mole_pos_q   <= mole_pos_d;
            hit_pulse_q  <= hit_pulse_d;
            miss_pulse_q <= miss_pulse_d;
            score_q      <= score_d;
            misses_q     <= misses_d;
`ifdef MOLE_NO_REPEAT_EN
            has_prev_q   <= has_prev_d;
`endif
        end
    end

    assign mole_valid = mole_valid_q;
    assign mole_pos   = mole_pos_q;
    assign hit_pulse  = hit_pulse_q;
    assign miss_pulse = miss_pulse_q;
    assign score      = score_q;
    assign misses     = misses_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_mole_scheduler.sv
// -----------------------------------------------------------------------------
// tb_mole_scheduler
//   Directed bench for mole_scheduler with NUM_HOLES=9, MIN_GAP=4, GAP_BITS=2,
//   UP_TIME=10. Every random word used keeps rand_data[9:8]=3, so each gap load
//   is 4+3=7 cycles. Inputs change 1 time unit after a rising edge; outputs
//   are sampled at that same point, i.e. they reflect the preceding edge.
// -----------------------------------------------------------------------------
module tb_mole_scheduler;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_PICK = 2'd2;
    localparam logic [1:0] S_UP   = 2'd3;

    logic        clock;
    logic        reset;
    logic [31:0] rand_data;
    logic        enable;
    logic        hit_valid;
    logic [3:0]  hit_index;
    logic        mole_valid;
    logic [3:0]  mole_pos;
    logic        hit_pulse;
    logic        miss_pulse;
    logic [15:0] score;
    logic [15:0] misses;
    logic [1:0]  dbg_state;

    int n_checks = 0;
    int n_fail   = 0;

    mole_scheduler #(
        .NUM_HOLES(9),
        .MIN_GAP  (4),
        .GAP_BITS (2),
        .UP_TIME  (10)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .rand_data (rand_data),
        .enable    (enable),
        .hit_valid (hit_valid),
        .hit_index (hit_index),
        .mole_valid(mole_valid),
        .mole_pos  (mole_pos),
        .hit_pulse (hit_pulse),
        .miss_pulse(miss_pulse),
        .score     (score),
        .misses    (misses),
        .dbg_state (dbg_state)
    );

    // clock / reset block
    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Precondition: the current sample is the first WAIT_GAP cycle (or a
    // later one). Checks n WAIT_GAP samples, then the PICK entry.
    task automatic run_gap(input int n);
        for (int i = 0; i < n; i++) begin
            check_eq("gap_state", dbg_state, S_WAIT);
            step();
        end
        check_eq("pick_entry", dbg_state, S_PICK);
    endtask

    initial begin
        int up_cycles;
        int miss_cnt;

        reset = 1'b1; enable = 1'b0; hit_valid = 1'b0; hit_index = 4'd0; rand_data = 32'd0;
        step(); step();
        check_eq("rst_state", dbg_state, S_IDLE);
        check_eq("rst_valid", mole_valid, 0);
        check_eq("rst_pos", mole_pos, 0);
        check_eq("rst_hit_pulse", hit_pulse, 0);
        check_eq("rst_miss_pulse", miss_pulse, 0);
        check_eq("rst_score", score, 0);
        check_eq("rst_misses", misses, 0);

        // First mole: gap 4+3, accept hole 5
        reset = 1'b0; enable = 1'b1; rand_data = 32'h0000_0305;
        step();
        run_gap(7);
        step();
        check_eq("first_state", dbg_state, S_UP);
        check_eq("first_valid", mole_valid, 1);
        check_eq("first_pos", mole_pos, 5);

        // Wrong hit ignored, then correct hit
        hit_valid = 1'b1; hit_index = 4'd3;
        step();
        check_eq("wrong_hit_valid", mole_valid, 1);
        check_eq("wrong_hit_pulse", hit_pulse, 0);
        check_eq("wrong_hit_score", score, 0);
        hit_index = 4'd5;
        step();
        check_eq("hit_pulse", hit_pulse, 1);
        check_eq("hit_valid_drop", mole_valid, 0);
        check_eq("hit_score", score, 1);
        check_eq("hit_misses", misses, 0);
        check_eq("hit_state", dbg_state, S_WAIT);
        hit_valid = 1'b0;
        step();
        check_eq("hit_pulse_one_cycle", hit_pulse, 0);
        run_gap(6);

        // Rejections: 12, 15, 9, then accept 2
        rand_data = 32'h0000_030C; step(); check_eq("rej12", dbg_state, S_PICK);
        rand_data = 32'h0000_030F; step(); check_eq("rej15", dbg_state, S_PICK);
        rand_data = 32'h0000_0309; step(); check_eq("rej9", dbg_state, S_PICK);
        check_eq("rej_valid", mole_valid, 0);
        rand_data = 32'h0000_0302; step();
        check_eq("acc2_state", dbg_state, S_UP);
        check_eq("acc2_pos", mole_pos, 2);

        // Timeout: mole up exactly 10 cycles, one miss pulse
        up_cycles = 0;
        miss_cnt  = 0;
        while (mole_valid && up_cycles < 20) begin
            up_cycles++;
            step();
        end
        check_eq("up_cycles", up_cycles, 10);
        check_eq("miss_pulse", miss_pulse, 1);
        check_eq("miss_no_hit_pulse", hit_pulse, 0);
        check_eq("miss_misses", misses, 1);
        check_eq("miss_score", score, 1);
        if (miss_pulse) miss_cnt++;
        step();
        if (miss_pulse) miss_cnt++;
        check_eq("miss_pulse_count", miss_cnt, 1);
        run_gap(6);

        // Hit on the expiry cycle counts as a hit
        rand_data = 32'h0000_0307;
        step();
        check_eq("acc7_pos", mole_pos, 7);
        repeat (9) step();
        check_eq("expiry_still_up", mole_valid, 1);
        hit_valid = 1'b1; hit_index = 4'd7;
        step();
        check_eq("expiry_hit_pulse", hit_pulse, 1);
        check_eq("expiry_miss_pulse", miss_pulse, 0);
        check_eq("expiry_score", score, 2);
        check_eq("expiry_misses", misses, 1);
        hit_valid = 1'b0;
        step();
        run_gap(6);

        // Score 3, then reset while UP (hit asserted to show override)
        rand_data = 32'h0000_0304;
        step();
        check_eq("acc4_pos", mole_pos, 4);
        hit_valid = 1'b1; hit_index = 4'd4;
        step();
        check_eq("score3", score, 3);
        hit_valid = 1'b0;
        step();
        run_gap(6);
        rand_data = 32'h0000_0306;
        step();
        check_eq("acc6_state", dbg_state, S_UP);
        reset = 1'b1; hit_valid = 1'b1; hit_index = 4'd6;
        step();
        check_eq("midup_rst_state", dbg_state, S_IDLE);
        check_eq("midup_rst_valid", mole_valid, 0);
        check_eq("midup_rst_pos", mole_pos, 0);
        check_eq("midup_rst_hit_pulse", hit_pulse, 0);
        check_eq("midup_rst_score", score, 0);
        check_eq("midup_rst_misses", misses, 0);
        reset = 1'b0; hit_valid = 1'b0;

        // enable=0 mid-WAIT_GAP holds score and position
        rand_data = 32'h0000_0301;
        step();
        run_gap(7);
        step();
        check_eq("acc1_pos", mole_pos, 1);
        hit_valid = 1'b1; hit_index = 4'd1;
        step();
        check_eq("score_after_rst", score, 1);
        hit_valid = 1'b0;
        step(); step();
        check_eq("pre_disable_state", dbg_state, S_WAIT);
        enable = 1'b0;
        step();
        check_eq("dis_state", dbg_state, S_IDLE);
        check_eq("dis_valid", mole_valid, 0);
        check_eq("dis_score", score, 1);
        check_eq("dis_pos", mole_pos, 1);
        hit_valid = 1'b1; hit_index = 4'd1;
        step();
        check_eq("idle_hit_pulse", hit_pulse, 0);
        check_eq("idle_hit_score", score, 1);
        hit_valid = 1'b0;

        // Same candidate as previous mole
        enable = 1'b1; rand_data = 32'h0000_0305;
        step();
        run_gap(7);
        step();
        check_eq("acc5b_pos", mole_pos, 5);
        hit_valid = 1'b1; hit_index = 4'd5;
        step();
        check_eq("score_5b", score, 2);
        hit_valid = 1'b0;
        step();
        run_gap(6);
        step();
`ifdef MOLE_NO_REPEAT_EN
        check_eq("repeat_rejected", dbg_state, S_PICK);
        rand_data = 32'h0000_0303;
        step();
        check_eq("norep_pos", mole_pos, 3);
        check_eq("norep_state", dbg_state, S_UP);
`else
        check_eq("repeat_allowed_state", dbg_state, S_UP);
        check_eq("repeat_allowed_pos", mole_pos, 5);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mole_scheduler.md
MOLE_SCHEDULER -- requirements
Module: mole_scheduler

Interface
REQ-001 Parameter NUM_HOLES, default 9, number of mole holes; SHALL be 2..16.
REQ-002 Parameter MIN_GAP, default 25000000, minimum idle cycles between moles; SHALL be >= 1.
REQ-003 Parameter GAP_BITS, default 24, width of the random gap extension taken from rand_data[GAP_BITS+7:8]; SHALL be 1..24.
REQ-004 Parameter UP_TIME, default 50000000, cycles a mole stays up unless hit; SHALL be >= 1.
REQ-005 clock  in  1  single clock; all logic on its rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 rand_data  in  32  free-running pseudo-random word from the upstream 32-bit LFSR, new value every cycle.
REQ-008 enable  in  1  game running; low forces IDLE.
REQ-009 hit_valid  in  1  one-cycle strobe: player struck a hole.
REQ-010 hit_index  in  4  hole struck; valid only with hit_valid.
REQ-011 mole_valid  out  1  a mole is currently up.
REQ-012 mole_pos  out  4  hole index of the current/last mole.
REQ-013 hit_pulse  out  1  one-cycle strobe: correct hit registered.
REQ-014 miss_pulse  out  1  one-cycle strobe: mole timed out unhit.
REQ-015 score  out  16  correct-hit count.
REQ-016 misses  out  16  timed-out mole count.

Function
REQ-017 FSM states SHALL be IDLE, WAIT_GAP, PICK, UP; all outputs registered.
REQ-018 IDLE: when enable=1, next state WAIT_GAP with gap counter loaded to MIN_GAP + rand_data[GAP_BITS+7:8] sampled that cycle.
REQ-019 WAIT_GAP SHALL last exactly the loaded count of cycles (decrement each cycle), then go to PICK.
REQ-020 PICK: each cycle sample cand = rand_data[3:0]; reject if cand >= NUM_HOLES and remain in PICK; on accept, next cycle mole_valid=1, mole_pos=cand, state UP, up counter loaded to UP_TIME.
REQ-021 UP: hit_valid=1 with hit_index==mole_pos SHALL, next cycle, deassert mole_valid, pulse hit_pulse, increment score, and enter WAIT_GAP with a fresh gap load per REQ-018.
REQ-022 UP: hit_valid with hit_index!=mole_pos, or any hit outside UP, SHALL be ignored (no count, no pulse).
REQ-023 UP: after UP_TIME cycles without a correct hit, next cycle deassert mole_valid, pulse miss_pulse, increment misses, enter WAIT_GAP with fresh gap load.
REQ-024 Correct hit in the same cycle the up counter expires SHALL count as a hit, not a miss.
REQ-025 score and misses SHALL saturate at 16'hFFFF.
REQ-026 enable=0 in any state SHALL, next cycle, enter IDLE, clear mole_valid, hold score/misses/mole_pos, emit no pulses.
REQ-027 hit_pulse and miss_pulse SHALL never be high in the same cycle and each lasts exactly one cycle.

Reset
REQ-028 reset=1 SHALL, on the next rising edge, set state IDLE, mole_valid=0, mole_pos=0, hit_pulse=0, miss_pulse=0, score=0, misses=0, counters=0, overriding all other inputs including mid-UP operation.

Configuration
REQ-029 Macro MOLE_NO_REPEAT_EN defined: PICK SHALL also reject cand equal to the previous mole_pos (except the first mole after reset).
REQ-030 Macro MOLE_NO_REPEAT_EN undefined: consecutive moles MAY share a position; no previous-position register exists.

Verification
REQ-031 Bench parameters NUM_HOLES=9, MIN_GAP=4, GAP_BITS=2, UP_TIME=10 for all scenarios below.
REQ-032 reset then enable=1 with rand_data=32'h0000_0305 -> 7 gap cycles (4+3), then PICK accepts 5, mole_valid=1, mole_pos=5.
REQ-033 rand_data[3:0] driven 12,15,9,2 in PICK -> three rejected cycles, mole_pos=2 on the fourth accept.
REQ-034 mole up, hit_index=3 (wrong) then hit_index=mole_pos -> wrong hit ignored, single hit_pulse, score=1, misses=0.
REQ-035 mole up, no hit -> mole_valid high exactly 10 cycles, miss_pulse once, misses=1; hit on expiry cycle -> score increments, misses unchanged.
REQ-036 reset asserted mid-UP with score=3 -> next edge all outputs zero; enable=0 mid-WAIT_GAP -> IDLE, score held; with MOLE_NO_REPEAT_EN and prior pos 5, candidate 5 rejected.
